// File: rtl/bist_sequencer.sv
// BIST control sequencer: IDLE -> (INIT -> RUN) x N_ROUNDS -> FIN -> DONE, all outputs registered.
// Optional macro BIST_RESTART_EN: start during INIT/RUN/FIN aborts and relaunches the test.
module bist_sequencer #(
  parameter int N_CYCLES      = 650,
  parameter int TOGGLE_PERIOD = 1,
  parameter int N_ROUNDS      = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic init,
  output logic running,
  output logic toggle,
  output logic finish,
  output logic bist_end,
  output logic [((N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1)-1:0] round
);

  localparam int CW = $clog2(N_CYCLES + 1);
  localparam int PW = (TOGGLE_PERIOD > 1) ? $clog2(TOGGLE_PERIOD) : 1;
  localparam int RW = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(N_CYCLES - 1);
  localparam logic [PW-1:0] PH_LAST    = PW'(TOGGLE_PERIOD - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(N_ROUNDS - 1);

  typedef enum logic [2:0] {IDLE, INIT, RUN, FIN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [PW-1:0]   ph_reg, ph_next;
  logic [RW-1:0]   round_reg, round_next;
  logic            init_next, running_next, toggle_next, finish_next, bist_end_next;

  // ph tracks counter mod TOGGLE_PERIOD so no divider is needed for the toggle decode.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ph_next    = ph_reg;
    round_next = round_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = INIT;
          round_next = '0;
        end
      end
      INIT: begin
        state_next = RUN;
        cnt_next   = '0;
        ph_next    = '0;
      end
      RUN: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next = '0;
          ph_next  = '0;
          if (round_reg < ROUND_LAST) begin
            state_next = INIT;
            round_next = round_reg + 1'b1;
          end else begin
            state_next = FIN;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
          ph_next  = (ph_reg == PH_LAST) ? '0 : ph_reg + 1'b1;
        end
      end
      FIN:     state_next = DONE;
      default: state_next = IDLE;
    endcase

`ifdef BIST_RESTART_EN
    if (start && (state_reg == INIT || state_reg == RUN || state_reg == FIN)) begin
      state_next = INIT;
      round_next = '0;
      cnt_next   = '0;
      ph_next    = '0;
    end
`endif

    // Outputs are decoded from the next state so they appear registered alongside it.
    init_next     = (state_next == INIT);
    running_next  = (state_next == RUN);
    toggle_next   = (state_next == RUN) && (ph_next == PH_LAST);
    finish_next   = (state_next == FIN);
    bist_end_next = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ph_reg    <= '0;
      round_reg <= '0;
      init      <= 1'b0;
      running   <= 1'b0;
      toggle    <= 1'b0;
      finish    <= 1'b0;
      bist_end  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ph_reg    <= ph_next;
      round_reg <= round_next;
      init      <= init_next;
      running   <= running_next;
      toggle    <= toggle_next;
      finish    <= finish_next;
      bist_end  <= bist_end_next;
    end
  end

  assign round = round_reg;

endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer: three configurations driven from shared start/reset,
// a timeline reference model, a vector table and scenario sequences.
module tb_bist_sequencer;

`ifdef BIST_RESTART_EN
  localparam bit RESTART = 1'b1;
`else
  localparam bit RESTART = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  // index 0: 650/1/1, index 1: 8/3/3, index 2: 8/2/1
  logic ini[3], run[3], tog[3], fin[3], bend[3];
  logic [0:0] rnd0;
  logic [1:0] rnd1;
  logic [0:0] rnd2;

  bist_sequencer #(.N_CYCLES(650), .TOGGLE_PERIOD(1), .N_ROUNDS(1)) dut_d (
    .clk(clk), .reset(reset), .start(start), .init(ini[0]), .running(run[0]),
    .toggle(tog[0]), .finish(fin[0]), .bist_end(bend[0]), .round(rnd0));
  bist_sequencer #(.N_CYCLES(8), .TOGGLE_PERIOD(3), .N_ROUNDS(3)) dut_m (
    .clk(clk), .reset(reset), .start(start), .init(ini[1]), .running(run[1]),
    .toggle(tog[1]), .finish(fin[1]), .bist_end(bend[1]), .round(rnd1));
  bist_sequencer #(.N_CYCLES(8), .TOGGLE_PERIOD(2), .N_ROUNDS(1)) dut_s (
    .clk(clk), .reset(reset), .start(start), .init(ini[2]), .running(run[2]),
    .toggle(tog[2]), .finish(fin[2]), .bist_end(bend[2]), .round(rnd2));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a launched test is a timeline of elapsed cycles e since the
  // init cycle; each round spans N+1 cycles, then one finish cycle, then done.
  int  mn[3]  = '{650, 8, 8};
  int  mtp[3] = '{1, 3, 2};
  int  mr[3]  = '{1, 3, 1};
  bit  act[3] = '{0, 0, 0};
  int  el[3]  = '{0, 0, 0};

  function automatic int tot(input int i);
    return (mn[i] + 1) * mr[i];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        act[i] <= 1'b0;
        el[i]  <= 0;
      end else if (start && (!act[i] || el[i] > tot(i))) begin
        act[i] <= 1'b1;
        el[i]  <= 0;
      end else if (start && act[i] && RESTART) begin
        el[i] <= 0;
      end else if (act[i] && el[i] <= tot(i)) begin
        el[i] <= el[i] + 1;
      end
    end
  end

  function automatic logic [12:0] expv(input int i);
    int l, p, rr;
    logic [12:0] v;
    l = mn[i] + 1;
    v = '0;
    if (act[i]) begin
      if (el[i] < tot(i)) begin
        rr = el[i] / l;
        p  = el[i] % l;
        v[12]  = (p == 0);
        v[11]  = (p != 0);
        v[10]  = (p != 0) && (p % mtp[i] == 0);
        v[7:0] = 8'(rr);
      end else if (el[i] == tot(i)) begin
        v[9]   = 1'b1;
        v[7:0] = 8'(mr[i] - 1);
      end else begin
        v[8]   = 1'b1;
        v[7:0] = 8'(mr[i] - 1);
      end
    end
    return v;
  endfunction

  function automatic logic [12:0] obs(input int i);
    logic [7:0] r8;
    case (i)
      0:       r8 = {7'b0, rnd0};
      1:       r8 = {6'b0, rnd1};
      default: r8 = {7'b0, rnd2};
    endcase
    return {ini[i], run[i], tog[i], fin[i], bend[i], r8};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) chk($sformatf("model_dut%0d", i), 32'(obs(i)), 32'(expv(i)));
    end
  end

  // Scenario counters
  int ci[3], cr[3], ct[3], cf[3];
  logic [1:0] rseq[$];

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      ci[i] = 0; cr[i] = 0; ct[i] = 0; cf[i] = 0;
    end
    rseq.delete();
  endtask

  // Apply inputs at a falling edge, let one rising edge pass, observe at the next falling edge.
  task automatic cycle(input bit r, input bit s);
    reset = r;
    start = s;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      ci[i] += int'(ini[i]);
      cr[i] += int'(run[i]);
      ct[i] += int'(tog[i]);
      cf[i] += int'(fin[i]);
    end
    if (ini[1]) rseq.push_back(rnd1);
  endtask

  typedef struct packed {
    bit       r;
    bit       s;
    bit [4:0] e;  // {init, running, toggle, finish, bist_end} of dut_s
  } vec_t;

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{r:1, s:0, e:5'b00000};
    tbl[1]  = '{r:1, s:1, e:5'b00000};  // reset wins over start
    tbl[2]  = '{r:0, s:1, e:5'b10000};  // start right after reset
    tbl[3]  = '{r:0, s:0, e:5'b01000};
    tbl[4]  = '{r:0, s:0, e:5'b01100};
    tbl[5]  = '{r:0, s:0, e:5'b01000};
    tbl[6]  = '{r:0, s:0, e:5'b01100};
    tbl[7]  = '{r:0, s:0, e:5'b01000};
    tbl[8]  = '{r:0, s:0, e:5'b01100};
    tbl[9]  = '{r:0, s:0, e:5'b01000};
    tbl[10] = '{r:0, s:0, e:5'b01100};
    tbl[11] = '{r:0, s:0, e:5'b00010};
    tbl[12] = '{r:0, s:0, e:5'b00001};
    tbl[13] = '{r:0, s:0, e:5'b00001};
    tbl[14] = '{r:0, s:1, e:5'b10000};  // relaunch from DONE
    tbl[15] = '{r:0, s:0, e:5'b01000};
    tbl[16] = '{r:1, s:0, e:5'b00000};
    tbl[17] = '{r:0, s:0, e:5'b00000};

    @(negedge clk);
    for (int k = 0; k < 18; k++) begin
      cycle(tbl[k].r, tbl[k].s);
      chk($sformatf("tbl%0d", k), 32'({ini[2], run[2], tog[2], fin[2], bend[2]}), 32'(tbl[k].e));
      if (k == 0) chk_en = 1'b1;
    end

    // Normal run on all three configurations
    cycle(1'b1, 1'b0);
    clear_counts();
    cycle(1'b0, 1'b1);
    repeat (660) cycle(1'b0, 1'b0);
    chk("d_init", ci[0], 1);
    chk("d_running", cr[0], 650);
    chk("d_toggle", ct[0], 650);
    chk("d_finish", cf[0], 1);
    chk("d_bist_end", 32'(bend[0]), 1);
    chk("m_init", ci[1], 3);
    chk("m_running", cr[1], 24);
    chk("m_toggle", ct[1], 6);
    chk("m_finish", cf[1], 1);
    chk("m_round_count", rseq.size(), 3);
    for (int j = 0; j < 3 && j < rseq.size(); j++) chk($sformatf("m_round_seq%0d", j), 32'(rseq[j]), j);
    chk("m_round_done", 32'(rnd1), 2);
    chk("s_toggle", ct[2], 4);

    // Start pulse three cycles into RUN
    cycle(1'b1, 1'b0);
    clear_counts();
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (20) cycle(1'b0, 1'b0);
    chk("mid_running", cr[2], RESTART ? 11 : 8);
    chk("mid_init", ci[2], RESTART ? 2 : 1);
    chk("mid_finish", cf[2], 1);
    chk("mid_bist_end", 32'(bend[2]), 1);

    // Reset five cycles into RUN
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    chk("rst_outputs", 32'({ini[2], run[2], tog[2], fin[2], bend[2]}), 0);
    clear_counts();
    repeat (15) cycle(1'b0, 1'b0);
    chk("rst_no_finish", cf[2], 0);
    chk("rst_no_bist_end", 32'(bend[2]), 0);
    clear_counts();
    cycle(1'b0, 1'b1);
    repeat (12) cycle(1'b0, 1'b0);
    chk("post_rst_init", ci[2], 1);
    chk("post_rst_running", cr[2], 8);
    chk("post_rst_toggle", ct[2], 4);
    chk("post_rst_finish", cf[2], 1);
    chk("post_rst_bist_end", 32'(bend[2]), 1);

    // Relaunch from DONE
    clear_counts();
    cycle(1'b0, 1'b1);
    chk("redo_bist_end_drop", 32'(bend[2]), 0);
    chk("redo_init", 32'(ini[2]), 1);
    repeat (12) cycle(1'b0, 1'b0);
    chk("redo_running", cr[2], 8);
    chk("redo_finish", cf[2], 1);
    chk("redo_bist_end", 32'(bend[2]), 1);

    // Random start/reset traffic checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_sequencer.md
BIST_SEQUENCER -- requirements
Module: bist_sequencer

Interface
REQ-001 The block SHALL have parameter N_CYCLES, default 650, running-phase length in clocks per round (legal range 1..65535).
REQ-002 The block SHALL have parameter TOGGLE_PERIOD, default 1, clocks between toggle pulses during running (legal range 1..N_CYCLES).
REQ-003 The block SHALL have parameter N_ROUNDS, default 1, number of init+run rounds per test (legal range 1..255).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, test request, sampled on each rising edge.
REQ-007 The block SHALL have port init, output, 1, high during each round's init cycle.
REQ-008 The block SHALL have port running, output, 1, high during the running phase.
REQ-009 The block SHALL have port toggle, output, 1, one-cycle stimulus pulse.
REQ-010 The block SHALL have port finish, output, 1, one-cycle end-of-test pulse.
REQ-011 The block SHALL have port bist_end, output, 1, sticky test-complete flag.
REQ-012 The block SHALL have port round, output, max(1,$clog2(N_ROUNDS)), index of the current round, zero-based.

Function
REQ-013 All outputs SHALL be registered Moore outputs decoded from states IDLE, INIT, RUN, FIN and DONE.
REQ-014 IDLE: all outputs 0; start=1 -> INIT, round=0.
REQ-015 INIT: init=1 for exactly one cycle; unconditionally -> RUN with the cycle counter at 0.
REQ-016 RUN: running=1 for exactly N_CYCLES cycles; counter increments 0..N_CYCLES-1, with width $clog2(N_CYCLES+1).
REQ-017 Within RUN, toggle SHALL be 1 in each cycle where (counter+1) mod TOGGLE_PERIOD == 0, giving floor(N_CYCLES/TOGGLE_PERIOD) pulses per round; toggle SHALL be 0 outside RUN.
REQ-018 Last RUN cycle: round<N_ROUNDS-1 -> INIT and round increments; otherwise -> FIN.
REQ-019 FIN: finish=1 for one cycle; -> DONE.
REQ-020 DONE: bist_end=1, held until reset or start; round holds N_ROUNDS-1.
REQ-021 start=1 in DONE SHALL clear bist_end and enter INIT with round=0 on the next cycle, as from IDLE.
REQ-022 Latency: start sampled high at edge k SHALL give init=1 after edge k; the first running cycle follows edge k+1.
REQ-023 start in INIT, RUN or FIN SHALL be handled per REQ-031/REQ-032.
REQ-024 start held high continuously SHALL re-launch the test only from IDLE or DONE, never mid-test.

Reset
REQ-025 reset=1 at a rising edge SHALL force IDLE, counter=0, round=0 and init, running, toggle, finish, bist_end all 0, from any state.
REQ-026 reset SHALL take priority over start at the same edge; the sequencer stays in IDLE.
REQ-027 After reset deasserts, the block SHALL accept start at the first following edge.
REQ-028 reset asserted mid-RUN SHALL produce no finish pulse and no bist_end.

Configuration
REQ-029 Macro BIST_RESTART_EN SHALL select the mid-test start behaviour.
REQ-030 The macro SHALL affect only the mid-test start behaviour defined in REQ-031 and REQ-032; all other behaviour is identical with or without it.
REQ-031 With BIST_RESTART_EN defined, start=1 in INIT, RUN or FIN SHALL abort the test without a finish pulse and enter INIT next cycle with round=0 and counter=0.
REQ-032 Without BIST_RESTART_EN, start in INIT, RUN or FIN SHALL be ignored and the test SHALL run to completion unchanged.

Verification
REQ-033 The bench SHALL cover a normal run: N_CYCLES=650, TOGGLE_PERIOD=1, N_ROUNDS=1; reset, then a start pulse -> 1 init cycle, 650 running cycles, 650 toggle pulses, 1 finish cycle, then bist_end=1.
REQ-034 The bench SHALL cover multiple rounds: N_CYCLES=8, TOGGLE_PERIOD=3, N_ROUNDS=3 -> init pulses 3, running 24 cycles, toggle pulses 6, round sequence 0,1,2, a single finish.
REQ-035 The bench SHALL cover a mid-test start: start pulse 3 cycles into RUN (N_CYCLES=8) -> without the macro, running stays high for 8 cycles total; with BIST_RESTART_EN, init re-asserts, running totals 3+8 cycles and finish occurs once.
REQ-036 The bench SHALL cover reset mid-test: reset for 1 cycle 5 cycles into RUN -> all outputs 0 on the next cycle, no finish, then a later start gives a full normal run.
REQ-037 The bench SHALL cover simultaneous reset and start: both high at the same edge -> IDLE, all outputs 0; start alone afterwards -> init on the next cycle.
REQ-038 The bench SHALL cover restart from DONE: start while bist_end=1 -> bist_end drops, init=1 on the next cycle, and a second full run follows.
